// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_SPACE = 2'd2,
    DRAIN      = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; flush wins over push/pop.
`default_nettype none

module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fetch_entry_t  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues word reads to the cache, holds them across misses,
// buffers returned words toward decode and handles redirects (including mid-miss).
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] cache_addr_o,
  output logic        cache_read_en_o,
  input  logic        cache_read_valid_i,
  input  logic [31:0] cache_read_word_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   pending_pc;
  logic [31:0]   pending_pc_next;
  logic [31:0]   redirect_target;

  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          full;
  logic          empty;

  assign redirect_target = redirect_pc_i & ~32'h3;

  assign pop         = !empty && instr_ready_i;
  assign push        = (state == REQ) && cache_read_valid_i && !redirect_i && !full;
  assign push_entry  = '{pc: fetch_pc, instr: cache_read_word_i};
  assign count_after = count + CW'(push) - CW'(pop);

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      pending_pc <= pending_pc_next;
    end
  end

  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    pending_pc_next = pending_pc;
    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect_i) fetch_pc_next = redirect_target;
      end
      REQ: begin
        if (redirect_i) begin
          if (cache_read_valid_i) begin
            fetch_pc_next = redirect_target;
          end else begin
            // Miss in flight: the request must complete before the new target is used.
            pending_pc_next = redirect_target;
            state_next      = DRAIN;
          end
        end else if (cache_read_valid_i) begin
          fetch_pc_next = fetch_pc + PC_INC;
          if (count_after == CW'(BUF_DEPTH)) state_next = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (redirect_i) begin
          fetch_pc_next = redirect_target;
          state_next    = REQ;
        end else if (pop) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (redirect_i) pending_pc_next = redirect_target;
        if (cache_read_valid_i) begin
          fetch_pc_next = redirect_i ? redirect_target : pending_pc;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cache_read_en_o = (state == REQ) || (state == DRAIN);
  assign cache_addr_o    = fetch_pc;
  assign instr_valid_o   = !empty;
  assign instr_o         = empty ? 32'h0 : head.instr;
  assign pc_o            = empty ? 32'h0 : head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed table-driven bench for instr_fetch_unit with a
//               simple hit/miss cache model.
// Revision    : 1.1
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] c_KEY      = 32'hA5A5_A5A5;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_TIMEOUT  = 100000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] cache_addr_o;
    logic        cache_read_en_o;
    logic        cache_read_valid_i = 1'b0;
    logic [31:0] cache_read_word_i  = 32'h0;
    logic        redirect_i         = 1'b0;
    logic [31:0] redirect_pc_i      = 32'h0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i      = 1'b0;

    instr_fetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .cache_addr_o       (cache_addr_o),
        .cache_read_en_o    (cache_read_en_o),
        .cache_read_valid_i (cache_read_valid_i),
        .cache_read_word_i  (cache_read_word_i),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .instr_o            (instr_o),
        .pc_o               (pc_o),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rst;
        int          tid;
        bit          ready;
        bit          miss;
        bit          redir;
        logic [31:0] rpc;
        bit          e_en;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;
    bit   done = 1'b0;

    function automatic vec_t mk(bit rst, int tid, bit ready, bit miss, bit redir,
                                logic [31:0] rpc, bit e_en, logic [31:0] e_addr,
                                bit e_valid, logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.tid = tid; v.ready = ready; v.miss = miss; v.redir = redir;
        v.rpc = rpc; v.e_en = e_en; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    // Reset row: asserted between clock edges, checked before any edge arrives.
    function automatic vec_t rr(int tid);
        return mk(1, tid, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endfunction

    initial begin
        #(c_TIMEOUT);
        if (!done) begin
            nerr++;
            $display("FAIL timeout: vector run did not finish within %0d ns (%0d vectors applied)",
                     c_TIMEOUT, nvec);
            $display("== TEST FAILED ==");
            $finish;
        end
    end

    initial begin
        // T1: hit every cycle, decode always ready
        vq.push_back(rr(1));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h0, 0, 32'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h8, 1, 32'h4));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'hC, 1, 32'h8));
        // T2: decode stalls, buffer fills, request re-issues after a pop
        vq.push_back(rr(2));
        vq.push_back(mk(0, 2, 0, 0, 0, 0, 1, 32'h0,  0, 32'h0));
        vq.push_back(mk(0, 2, 0, 0, 0, 0, 1, 32'h4,  1, 32'h0));
        vq.push_back(mk(0, 2, 0, 0, 0, 0, 0, 32'h8,  1, 32'h0));
        vq.push_back(mk(0, 2, 0, 0, 0, 0, 0, 32'h8,  1, 32'h0));
        vq.push_back(mk(0, 2, 1, 0, 0, 0, 1, 32'h8,  1, 32'h4));
        vq.push_back(mk(0, 2, 1, 0, 0, 0, 1, 32'hC,  1, 32'h8));
        vq.push_back(mk(0, 2, 1, 0, 0, 0, 1, 32'h10, 1, 32'hC));
        // T3: redirect during a miss at 0x114
        vq.push_back(rr(3));
        vq.push_back(mk(0, 3, 1, 0, 1, 32'h114, 1, 32'h114, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 1, 0, 32'h0,   1, 32'h114, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 1, 1, 32'h214, 1, 32'h114, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 1, 0, 32'h0,   1, 32'h114, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 1, 0, 32'h0,   1, 32'h114, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 1, 0, 32'h0,   1, 32'h114, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 0, 0, 32'h0,   1, 32'h214, 0, 32'h0));
        vq.push_back(mk(0, 3, 1, 0, 0, 32'h0,   1, 32'h218, 1, 32'h214));
        vq.push_back(mk(0, 3, 1, 0, 0, 32'h0,   1, 32'h21C, 1, 32'h218));
        // T4: redirect coinciding with a hit and a pop
        vq.push_back(rr(4));
        vq.push_back(mk(0, 4, 1, 0, 1, 32'h110, 1, 32'h110, 0, 32'h0));
        vq.push_back(mk(0, 4, 1, 0, 0, 32'h0,   1, 32'h114, 1, 32'h110));
        vq.push_back(mk(0, 4, 1, 0, 0, 32'h0,   1, 32'h118, 1, 32'h114));
        vq.push_back(mk(0, 4, 1, 0, 1, 32'h314, 1, 32'h314, 0, 32'h0));
        vq.push_back(mk(0, 4, 1, 0, 0, 32'h0,   1, 32'h318, 1, 32'h314));
        vq.push_back(mk(0, 4, 1, 0, 0, 32'h0,   1, 32'h31C, 1, 32'h318));
        // T5: unaligned target near the top of memory, PC wraps
        vq.push_back(rr(5));
        vq.push_back(mk(0, 5, 1, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0, 32'h0));
        vq.push_back(mk(0, 5, 1, 0, 0, 32'h0, 1, 32'h0, 1, 32'hFFFF_FFFC));
        vq.push_back(mk(0, 5, 1, 0, 0, 32'h0, 1, 32'h4, 1, 32'h0));
        // T6: reset asserted mid-miss with a word buffered
        vq.push_back(rr(6));
        vq.push_back(mk(0, 6, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0));
        vq.push_back(mk(0, 6, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0));
        vq.push_back(mk(0, 6, 0, 1, 0, 0, 1, 32'h4, 1, 32'h0));
        vq.push_back(rr(6));
        vq.push_back(mk(0, 6, 1, 0, 0, 0, 1, 32'h0, 0, 32'h0));
        vq.push_back(mk(0, 6, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0));
        // T7: redirect while waiting for buffer space
        vq.push_back(rr(7));
        vq.push_back(mk(0, 7, 0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0));
        vq.push_back(mk(0, 7, 0, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0));
        vq.push_back(mk(0, 7, 0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0));
        vq.push_back(mk(0, 7, 0, 0, 1, 32'h400, 1, 32'h400, 0, 32'h0));
        vq.push_back(mk(0, 7, 0, 0, 0, 32'h0,   1, 32'h404, 1, 32'h400));
        vq.push_back(mk(0, 7, 0, 0, 0, 32'h0,   0, 32'h408, 1, 32'h400));
        // T8: second redirect during DRAIN overrides the first
        vq.push_back(rr(8));
        vq.push_back(mk(0, 8, 1, 0, 1, 32'h500, 1, 32'h500, 0, 32'h0));
        vq.push_back(mk(0, 8, 1, 1, 1, 32'h600, 1, 32'h500, 0, 32'h0));
        vq.push_back(mk(0, 8, 1, 1, 1, 32'h700, 1, 32'h500, 0, 32'h0));
        vq.push_back(mk(0, 8, 1, 0, 0, 32'h0,   1, 32'h700, 0, 32'h0));
        vq.push_back(mk(0, 8, 1, 0, 0, 32'h0,   1, 32'h704, 1, 32'h700));

        #2;
        for (int i = 0; i < vq.size(); i++) begin
            vec_t        v;
            logic [31:0] e_instr;
            v = vq[i];
            if (v.rst) begin
                rst_i              = 1'b1;
                redirect_i         = 1'b0;
                cache_read_valid_i = 1'b0;
                #1;
                if (cache_read_en_o !== 1'b0 || cache_addr_o !== c_RESET_PC ||
                    instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin
                    nerr++;
                    $display("FAIL t%0d row%0d reset state: en=%0b addr=%h valid=%0b pc=%h instr=%h",
                             v.tid, i, cache_read_en_o, cache_addr_o, instr_valid_o, pc_o, instr_o);
                end
            end else begin
                @(negedge clk_i);
                rst_i              = 1'b0;
                instr_ready_i      = v.ready;
                redirect_i         = v.redir;
                redirect_pc_i      = v.rpc;
                cache_read_valid_i = cache_read_en_o && !v.miss;
                cache_read_word_i  = cache_addr_o ^ c_KEY;
                @(posedge clk_i);
                #1;
            end
            e_instr = v.e_valid ? (v.e_pc ^ c_KEY) : 32'h0;
            nvec++;
            if (cache_read_en_o !== v.e_en || cache_addr_o !== v.e_addr ||
                instr_valid_o !== v.e_valid || pc_o !== v.e_pc || instr_o !== e_instr) begin
                nerr++;
                $display("FAIL t%0d row%0d: got en=%0b addr=%h valid=%0b pc=%h instr=%h, want en=%0b addr=%h valid=%0b pc=%h instr=%h",
                         v.tid, i, cache_read_en_o, cache_addr_o, instr_valid_o, pc_o, instr_o,
                         v.e_en, v.e_addr, v.e_valid, v.e_pc, e_instr);
            end
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        if (nerr == 0) $display("== TEST PASSED ==");
        else           $display("== TEST FAILED ==");
        $finish;
    end

endmodule

`default_nettype wire
